id_ex_stage: RTL and testbench

//  ID/EX pipeline register with load-use hazard detection. Captures decoded operands,

---
 rtl/id_ex_stage_pkg.sv | 31 +++
 rtl/id_ex_stage_hazard_detect.sv | 20 ++
 rtl/id_ex_stage.sv | 107 ++++++++++
 tb/tb_id_ex_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared ID/EX definitions: ALU operation encodings, control bundle layout
// and the bubble (all-zero control) constant.
package id_ex_stage_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } aluOp_e;

  // Field order is MSB first: RegWrite down to the ALU operation.
  typedef struct packed {
    logic   regWrite;
    logic   memRead;
    logic   memWrite;
    logic   memtoReg;
    logic   aluSrc;
    logic   regDst;
    aluOp_e aluOp;
  } ctrl_t;

  localparam int unsigned CTRL_WIDTH = $bits(ctrl_t);

  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination is a source of
// the instruction in ID forces a one-cycle stall.
module hazard_detect #(
  parameter int unsigned REG_DIR_WIDTH = 3
) (
  input  logic                     idexValid,
  input  logic                     idexMemRead,
  input  logic [REG_DIR_WIDTH-1:0] idexRegisterRt,
  input  logic                     ifidValid,
  input  logic [REG_DIR_WIDTH-1:0] ifidRegisterRs,
  input  logic [REG_DIR_WIDTH-1:0] ifidRegisterRt,
  output logic                     stall
);

  always_comb begin
    stall = idexValid & idexMemRead & (idexRegisterRt != '0) & ifidValid &
            ((idexRegisterRt == ifidRegisterRs) | (idexRegisterRt == ifidRegisterRt));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands and control, inserts
// bubbles on flush or load-use stall, and counts bubbles with saturation.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned REG_DIR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     Hold,
  input  logic                     Flush,
  input  logic [REG_DIR_WIDTH-1:0] IFIDRegisterRs,
  input  logic [REG_DIR_WIDTH-1:0] IFIDRegisterRt,
  input  logic [REG_DIR_WIDTH-1:0] IFIDRegisterRd,
  input  logic [DATA_WIDTH-1:0]    IFIDReadData1,
  input  logic [DATA_WIDTH-1:0]    IFIDReadData2,
  input  logic [DATA_WIDTH-1:0]    IFIDImm,
  input  logic                     IFIDValid,
  input  logic                     IFIDRegWrite,
  input  logic                     IFIDMemRead,
  input  logic                     IFIDMemWrite,
  input  logic                     IFIDMemtoReg,
  input  logic                     IFIDALUSrc,
  input  logic                     IFIDRegDst,
  input  logic [2:0]               IFIDALUOp,
  output logic [REG_DIR_WIDTH-1:0] IDEXRegisterRs,
  output logic [REG_DIR_WIDTH-1:0] IDEXRegisterRt,
  output logic [REG_DIR_WIDTH-1:0] IDEXRegisterRd,
  output logic [DATA_WIDTH-1:0]    IDEXReadData1,
  output logic [DATA_WIDTH-1:0]    IDEXReadData2,
  output logic [DATA_WIDTH-1:0]    IDEXImm,
  output logic                     IDEXRegWrite,
  output logic                     IDEXMemRead,
  output logic                     IDEXMemWrite,
  output logic                     IDEXMemtoReg,
  output logic                     IDEXALUSrc,
  output logic                     IDEXRegDst,
  output logic [2:0]               IDEXALUOp,
  output logic                     IDEXValid,
  output logic                     Stall,
  output logic [CNT_WIDTH-1:0]     BubbleCount
);

  ctrl_t idCtrl;
  ctrl_t exCtrl;
  logic  loadBubble;

  always_comb begin
    idCtrl = '{regWrite: IFIDRegWrite, memRead: IFIDMemRead, memWrite: IFIDMemWrite,
               memtoReg: IFIDMemtoReg, aluSrc: IFIDALUSrc, regDst: IFIDRegDst,
               aluOp: aluOp_e'(IFIDALUOp)};
    loadBubble = Flush | Stall;
  end

  hazard_detect #(.REG_DIR_WIDTH(REG_DIR_WIDTH)) uHazardDetect (
    .idexValid      (IDEXValid),
    .idexMemRead    (exCtrl.memRead),
    .idexRegisterRt (IDEXRegisterRt),
    .ifidValid      (IFIDValid),
    .ifidRegisterRs (IFIDRegisterRs),
    .ifidRegisterRt (IFIDRegisterRt),
    .stall          (Stall)
  );

  // Flush and stall share one path: addresses/data still load, control and valid clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IDEXRegisterRs <= '0;
      IDEXRegisterRt <= '0;
      IDEXRegisterRd <= '0;
      IDEXReadData1  <= '0;
      IDEXReadData2  <= '0;
      IDEXImm        <= '0;
      exCtrl         <= BUBBLE_CTRL;
      IDEXValid      <= 1'b0;
      BubbleCount    <= '0;
    end else if (!Hold) begin
      IDEXRegisterRs <= IFIDRegisterRs;
      IDEXRegisterRt <= IFIDRegisterRt;
      IDEXRegisterRd <= IFIDRegisterRd;
      IDEXReadData1  <= IFIDReadData1;
      IDEXReadData2  <= IFIDReadData2;
      IDEXImm        <= IFIDImm;
      if (loadBubble) begin
        exCtrl    <= BUBBLE_CTRL;
        IDEXValid <= 1'b0;
        if (BubbleCount != '1) BubbleCount <= BubbleCount + CNT_WIDTH'(1);
      end else begin
        exCtrl    <= idCtrl;
        IDEXValid <= IFIDValid;
      end
    end
  end

  always_comb begin
    IDEXRegWrite = exCtrl.regWrite;
    IDEXMemRead  = exCtrl.memRead;
    IDEXMemWrite = exCtrl.memWrite;
    IDEXMemtoReg = exCtrl.memtoReg;
    IDEXALUSrc   = exCtrl.aluSrc;
    IDEXRegDst   = exCtrl.regDst;
    IDEXALUOp    = exCtrl.aluOp;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use stall, false-stall checks,
// flush/stall overlap, hold freeze and bubble counter saturation.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Hold, Flush;
  logic [2:0]  IFIDRegisterRs, IFIDRegisterRt, IFIDRegisterRd;
  logic [31:0] IFIDReadData1, IFIDReadData2, IFIDImm;
  logic        IFIDValid, IFIDRegWrite, IFIDMemRead, IFIDMemWrite, IFIDMemtoReg;
  logic        IFIDALUSrc, IFIDRegDst;
  logic [2:0]  IFIDALUOp;

  logic [2:0]  IDEXRegisterRs, IDEXRegisterRt, IDEXRegisterRd;
  logic [31:0] IDEXReadData1, IDEXReadData2, IDEXImm;
  logic        IDEXRegWrite, IDEXMemRead, IDEXMemWrite, IDEXMemtoReg, IDEXALUSrc, IDEXRegDst;
  logic [2:0]  IDEXALUOp;
  logic        IDEXValid, Stall;
  logic [15:0] BubbleCount;

  logic [2:0]  satRs, satRt, satRd;
  logic [31:0] satData1, satData2, satImm;
  logic        satRegWrite, satMemRead, satMemWrite, satMemtoReg, satALUSrc, satRegDst;
  logic [2:0]  satALUOp;
  logic        satValid, satStall;
  logic [3:0]  satCount;

  int unsigned vecCount  = 0;
  int unsigned missCount = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .Hold(Hold), .Flush(Flush),
    .IFIDRegisterRs(IFIDRegisterRs), .IFIDRegisterRt(IFIDRegisterRt), .IFIDRegisterRd(IFIDRegisterRd),
    .IFIDReadData1(IFIDReadData1), .IFIDReadData2(IFIDReadData2), .IFIDImm(IFIDImm),
    .IFIDValid(IFIDValid), .IFIDRegWrite(IFIDRegWrite), .IFIDMemRead(IFIDMemRead),
    .IFIDMemWrite(IFIDMemWrite), .IFIDMemtoReg(IFIDMemtoReg), .IFIDALUSrc(IFIDALUSrc),
    .IFIDRegDst(IFIDRegDst), .IFIDALUOp(IFIDALUOp),
    .IDEXRegisterRs(IDEXRegisterRs), .IDEXRegisterRt(IDEXRegisterRt), .IDEXRegisterRd(IDEXRegisterRd),
    .IDEXReadData1(IDEXReadData1), .IDEXReadData2(IDEXReadData2), .IDEXImm(IDEXImm),
    .IDEXRegWrite(IDEXRegWrite), .IDEXMemRead(IDEXMemRead), .IDEXMemWrite(IDEXMemWrite),
    .IDEXMemtoReg(IDEXMemtoReg), .IDEXALUSrc(IDEXALUSrc), .IDEXRegDst(IDEXRegDst),
    .IDEXALUOp(IDEXALUOp), .IDEXValid(IDEXValid), .Stall(Stall), .BubbleCount(BubbleCount)
  );

  id_ex_stage #(.CNT_WIDTH(4)) dutSat (
    .clk(clk), .rst_n(rst_n), .Hold(Hold), .Flush(Flush),
    .IFIDRegisterRs(IFIDRegisterRs), .IFIDRegisterRt(IFIDRegisterRt), .IFIDRegisterRd(IFIDRegisterRd),
    .IFIDReadData1(IFIDReadData1), .IFIDReadData2(IFIDReadData2), .IFIDImm(IFIDImm),
    .IFIDValid(IFIDValid), .IFIDRegWrite(IFIDRegWrite), .IFIDMemRead(IFIDMemRead),
    .IFIDMemWrite(IFIDMemWrite), .IFIDMemtoReg(IFIDMemtoReg), .IFIDALUSrc(IFIDALUSrc),
    .IFIDRegDst(IFIDRegDst), .IFIDALUOp(IFIDALUOp),
    .IDEXRegisterRs(satRs), .IDEXRegisterRt(satRt), .IDEXRegisterRd(satRd),
    .IDEXReadData1(satData1), .IDEXReadData2(satData2), .IDEXImm(satImm),
    .IDEXRegWrite(satRegWrite), .IDEXMemRead(satMemRead), .IDEXMemWrite(satMemWrite),
    .IDEXMemtoReg(satMemtoReg), .IDEXALUSrc(satALUSrc), .IDEXRegDst(satRegDst),
    .IDEXALUOp(satALUOp), .IDEXValid(satValid), .Stall(satStall), .BubbleCount(satCount)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic setId(input logic valid, input logic [2:0] rs, input logic [2:0] rt,
                       input logic [2:0] rd, input logic regWrite, input logic memRead);
    IFIDValid      = valid;
    IFIDRegisterRs = rs;
    IFIDRegisterRt = rt;
    IFIDRegisterRd = rd;
    IFIDReadData1  = 32'h1000_0000 | 32'(rs);
    IFIDReadData2  = 32'h2000_0000 | 32'(rt);
    IFIDImm        = 32'hFFFF_FFF0 | 32'(rd);
    IFIDRegWrite   = regWrite;
    IFIDMemRead    = memRead;
    IFIDMemWrite   = 1'b0;
    IFIDMemtoReg   = memRead;
    IFIDALUSrc     = memRead;
    IFIDRegDst     = ~memRead;
    IFIDALUOp      = 3'd0;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    Hold  = 1'b0;
    Flush = 1'b0;
    setId(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    #12 rst_n = 1'b1;

    // 1: reset mid-traffic, then first capture
    setId(1'b1, 3'd5, 3'd6, 3'd7, 1'b1, 1'b1);
    IFIDALUOp = 3'd3;
    step();
    checkVal("pre_valid", 32'(IDEXValid), 32'd1);
    checkVal("pre_aluop", 32'(IDEXALUOp), 32'd3);
    #3 rst_n = 1'b0;
    #1;
    checkVal("rst_valid", 32'(IDEXValid), 32'd0);
    checkVal("rst_memread", 32'(IDEXMemRead), 32'd0);
    checkVal("rst_regwrite", 32'(IDEXRegWrite), 32'd0);
    checkVal("rst_rs", 32'(IDEXRegisterRs), 32'd0);
    checkVal("rst_data1", IDEXReadData1, 32'd0);
    checkVal("rst_aluop", 32'(IDEXALUOp), 32'd0);
    checkVal("rst_count", 32'(BubbleCount), 32'd0);
    checkVal("rst_stall", 32'(Stall), 32'd0);
    #1 rst_n = 1'b1;
    setId(1'b1, 3'd2, 3'd3, 3'd4, 1'b1, 1'b0);
    step();
    checkVal("cap_rs", 32'(IDEXRegisterRs), 32'd2);
    checkVal("cap_rt", 32'(IDEXRegisterRt), 32'd3);
    checkVal("cap_valid", 32'(IDEXValid), 32'd1);
    checkVal("cap_regwrite", 32'(IDEXRegWrite), 32'd1);
    checkVal("cap_data2", IDEXReadData2, 32'h2000_0003);

    // 2: load-use stall lasts one cycle
    setId(1'b1, 3'd1, 3'd3, 3'd0, 1'b1, 1'b1);
    step();
    setId(1'b1, 3'd3, 3'd4, 3'd5, 1'b1, 1'b0);
    #1 checkVal("lu_stall", 32'(Stall), 32'd1);
    step();
    checkVal("lu_bub_valid", 32'(IDEXValid), 32'd0);
    checkVal("lu_bub_regwrite", 32'(IDEXRegWrite), 32'd0);
    checkVal("lu_bub_memread", 32'(IDEXMemRead), 32'd0);
    checkVal("lu_count", 32'(BubbleCount), 32'd1);
    checkVal("lu_stall_clear", 32'(Stall), 32'd0);
    step();
    checkVal("lu_load_valid", 32'(IDEXValid), 32'd1);
    checkVal("lu_load_rs", 32'(IDEXRegisterRs), 32'd3);
    checkVal("lu_load_rd", 32'(IDEXRegisterRd), 32'd5);
    checkVal("lu_count_hold", 32'(BubbleCount), 32'd1);

    // 3: no false stalls
    setId(1'b1, 3'd1, 3'd0, 3'd0, 1'b1, 1'b1);
    step();
    setId(1'b1, 3'd0, 3'd0, 3'd2, 1'b1, 1'b0);
    #1 checkVal("r0_stall", 32'(Stall), 32'd0);
    setId(1'b1, 3'd1, 3'd3, 3'd0, 1'b1, 1'b1);
    step();
    setId(1'b1, 3'd1, 3'd2, 3'd6, 1'b1, 1'b0);
    #1 checkVal("nodep_stall", 32'(Stall), 32'd0);
    step();
    checkVal("nodep_valid", 32'(IDEXValid), 32'd1);
    checkVal("nodep_count", 32'(BubbleCount), 32'd1);

    // 4: flush coinciding with stall
    setId(1'b1, 3'd1, 3'd3, 3'd0, 1'b1, 1'b1);
    step();
    setId(1'b1, 3'd3, 3'd1, 3'd7, 1'b1, 1'b0);
    Flush = 1'b1;
    #1 checkVal("fs_stall", 32'(Stall), 32'd1);
    step();
    Flush = 1'b0;
    checkVal("fs_valid", 32'(IDEXValid), 32'd0);
    checkVal("fs_count", 32'(BubbleCount), 32'd2);
    step();
    checkVal("fs_next_valid", 32'(IDEXValid), 32'd1);
    checkVal("fs_next_rd", 32'(IDEXRegisterRd), 32'd7);
    checkVal("fs_next_count", 32'(BubbleCount), 32'd2);

    // 5: hold during a stall
    setId(1'b1, 3'd1, 3'd3, 3'd0, 1'b1, 1'b1);
    step();
    setId(1'b1, 3'd5, 3'd3, 3'd4, 1'b1, 1'b0);
    Hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkVal($sformatf("hold_stall%0d", i), 32'(Stall), 32'd1);
      checkVal($sformatf("hold_memread%0d", i), 32'(IDEXMemRead), 32'd1);
      checkVal($sformatf("hold_rs%0d", i), 32'(IDEXRegisterRs), 32'd1);
      checkVal($sformatf("hold_count%0d", i), 32'(BubbleCount), 32'd2);
    end
    Hold = 1'b0;
    step();
    checkVal("hold_bub_valid", 32'(IDEXValid), 32'd0);
    checkVal("hold_bub_memread", 32'(IDEXMemRead), 32'd0);
    checkVal("hold_count_after", 32'(BubbleCount), 32'd3);
    step();
    checkVal("hold_next_rs", 32'(IDEXRegisterRs), 32'd5);
    checkVal("hold_next_valid", 32'(IDEXValid), 32'd1);

    // 6: counter saturation on the 4-bit instance
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    checkVal("sat_rst", 32'(satCount), 32'd0);
    Flush = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) checkVal("sat_14", 32'(satCount), 32'd14);
      if (i == 15) checkVal("sat_15", 32'(satCount), 32'd15);
    end
    Flush = 1'b0;
    checkVal("sat_20", 32'(satCount), 32'd15);
    checkVal("wide_20", 32'(BubbleCount), 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
